// File: rtl/if_id_pipeline_reg.sv
// IF/ID pipeline register for the 5-stage MIPS pipeline.
// Holds the fetched instruction word and its PC+4 for the decode stage.
// Slices the held word into decode fields and supports hazard stall and
// branch/jump flush. A saturating counter tracks how many consecutive cycles
// a real instruction has been held by a stall, for debug visibility.
module if_id_pipeline_reg #(
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0000,  // sll $0,$0,0
    parameter int          STALL_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    // Fetch side
    input  logic [31:0]            if_instr,
    input  logic [31:0]            if_pc_plus4,
    input  logic                   if_valid,
    // Hazard / branch control
    input  logic                   stall,
    input  logic                   flush,
    output logic                   if_ready,
    // Decode side
    output logic [31:0]            id_instr,
    output logic [31:0]            id_pc_plus4,
    output logic                   id_valid,
    output logic [5:0]             id_opcode,
    output logic [4:0]             id_rs,
    output logic [4:0]             id_rt,
    output logic [4:0]             id_rd,
    output logic [4:0]             id_shamt,
    output logic [5:0]             id_funct,
    output logic [15:0]            id_imm16,
    output logic [25:0]            id_jtarget,
    // Debug
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = {STALL_CNT_W{1'b1}};

    logic [31:0]            r_instr;
    logic [31:0]            r_pc_plus4;
    logic                   r_valid;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    // A stall that is also being flushed does not hold anything: the bubble
    // replaces the held word and fetch is free to move on.
    logic w_hold;
    logic w_count_stall;

    assign w_hold        = stall & ~flush;
    assign w_count_stall = w_hold & r_valid;

    // Fetch may advance unless decode is holding its current word.
    assign if_ready = ~w_hold;

    // Pipeline word register: reset > flush > stall > load.
    // NOTE: reset is in the sensitivity list so it clears the stage between
    // edges; all state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr    <= NOP_INSTR;
            r_pc_plus4 <= 32'h0000_0000;
            r_valid    <= 1'b0;
        end else if (flush) begin
            // Squash the wrong-path word; PC+4 is left as-is.
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (stall) begin
            r_instr    <= r_instr;
            r_pc_plus4 <= r_pc_plus4;
            r_valid    <= r_valid;
        end else if (if_valid) begin
            r_instr    <= if_instr;
            r_pc_plus4 <= if_pc_plus4;
            r_valid    <= 1'b1;
        end else begin
            // Fetch bubble: decode sees a NOP, PC+4 still tracks fetch.
            r_instr    <= NOP_INSTR;
            r_pc_plus4 <= if_pc_plus4;
            r_valid    <= 1'b0;
        end
    end

    // Consecutive held-instruction counter, saturating so a long stall never
    // reads back as a short one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_count_stall) begin
            if (r_stall_cnt != STALL_CNT_MAX) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end else begin
            r_stall_cnt <= '0;
        end
    end

    assign id_instr    = r_instr;
    assign id_pc_plus4 = r_pc_plus4;
    assign id_valid    = r_valid;
    assign stall_cnt   = r_stall_cnt;

    // Decode fields are raw slices of the held word, never gated by valid;
    // a bubble reads as all-zero fields because NOP_INSTR is all zeros.
    assign id_opcode  = r_instr[31:26];
    assign id_rs      = r_instr[25:21];
    assign id_rt      = r_instr[20:16];
    assign id_rd      = r_instr[15:11];
    assign id_shamt   = r_instr[10:6];
    assign id_funct   = r_instr[5:0];
    assign id_imm16   = r_instr[15:0];
    assign id_jtarget = r_instr[25:0];

endmodule

// File: tb/tb_if_id_pipeline_reg.sv
// Testbench for if_id_pipeline_reg. Directed vectors push their expected
// post-edge state into a scoreboard queue; a monitor pops one entry after
// every rising edge and compares it with the registered outputs.
module tb_if_id_pipeline_reg;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic [7:0]  cnt;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] if_instr;
    logic [31:0] if_pc_plus4;
    logic        if_valid;
    logic        stall;
    logic        flush;
    logic        if_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;
    logic        id_valid;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [4:0]  id_shamt;
    logic [5:0]  id_funct;
    logic [15:0] id_imm16;
    logic [25:0] id_jtarget;
    logic [7:0]  stall_cnt;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   vec_id   = 0;
    exp_t sb_q[$];

    if_id_pipeline_reg #(
        .NOP_INSTR  (32'h0000_0000),
        .STALL_CNT_W(8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .if_instr   (if_instr),
        .if_pc_plus4(if_pc_plus4),
        .if_valid   (if_valid),
        .stall      (stall),
        .flush      (flush),
        .if_ready   (if_ready),
        .id_instr   (id_instr),
        .id_pc_plus4(id_pc_plus4),
        .id_valid   (id_valid),
        .id_opcode  (id_opcode),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rd      (id_rd),
        .id_shamt   (id_shamt),
        .id_funct   (id_funct),
        .id_imm16   (id_imm16),
        .id_jtarget (id_jtarget),
        .stall_cnt  (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, check the combinational
    // ready, and queue the state expected after the following rising edge.
    task automatic step(input logic [31:0] instr, input logic [31:0] pc,
                        input logic vld, input logic stl, input logic fls,
                        input logic exp_rdy, input logic [31:0] e_instr,
                        input logic [31:0] e_pc, input logic e_valid,
                        input logic [7:0] e_cnt);
        exp_t e;
        @(negedge clk);
        if_instr    = instr;
        if_pc_plus4 = pc;
        if_valid    = vld;
        stall       = stl;
        flush       = fls;
        #1;
        check($sformatf("if_ready[v%0d]", vec_id), 64'(if_ready), 64'(exp_rdy));
        e.instr = e_instr;
        e.pc    = e_pc;
        e.valid = e_valid;
        e.cnt   = e_cnt;
        sb_q.push_back(e);
        vec_id++;
    endtask

    // Monitor: the register presents a new state after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("id_instr",    64'(id_instr),    64'(e.instr));
                check("id_pc_plus4", 64'(id_pc_plus4), 64'(e.pc));
                check("id_valid",    64'(id_valid),    64'(e.valid));
                check("stall_cnt",   64'(stall_cnt),   64'(e.cnt));
                check("id_fields",
                      64'({id_opcode, id_rs, id_rt, id_rd, id_shamt, id_funct}),
                      64'(e.instr));
                check("id_imm16",    64'(id_imm16),    64'(e.instr[15:0]));
                check("id_jtarget",  64'(id_jtarget),  64'(e.instr[25:0]));
            end
        end
    end

    initial begin
        int drain;
        if_instr    = 32'h0;
        if_pc_plus4 = 32'h0;
        if_valid    = 1'b0;
        stall       = 1'b0;
        flush       = 1'b0;
        reset       = 1'b1;

        // Reset state before any clock edge has occurred.
        #1;
        check("rst_instr", 64'(id_instr),  64'h0);
        check("rst_valid", 64'(id_valid),  64'h0);
        check("rst_imm16", 64'(id_imm16),  64'h0);
        check("rst_cnt",   64'(stall_cnt), 64'h0);
        check("rst_pc",    64'(id_pc_plus4), 64'h0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;

        // Plain load: addi $t0,$zero,-292.
        step(32'h2008_FEDC, 32'h0000_0404, 1, 0, 0, 1, 32'h2008_FEDC, 32'h404, 1, 0);
        @(posedge clk);
        #2;
        check("load_opcode", 64'(id_opcode), 64'h08);
        check("load_rs",     64'(id_rs),     64'h0);
        check("load_rt",     64'(id_rt),     64'h8);
        check("load_imm16",  64'(id_imm16),  64'hFEDC);

        // Stall hold: the held lw survives three stalled edges.
        step(32'h8C09_1234, 32'h0000_0408, 1, 0, 0, 1, 32'h8C09_1234, 32'h408, 1, 0);
        step(32'hDEAD_BEEF, 32'h0000_040C, 1, 1, 0, 0, 32'h8C09_1234, 32'h408, 1, 1);
        step(32'hDEAD_BEEF, 32'h0000_040C, 1, 1, 0, 0, 32'h8C09_1234, 32'h408, 1, 2);
        step(32'hDEAD_BEEF, 32'h0000_040C, 1, 1, 0, 0, 32'h8C09_1234, 32'h408, 1, 3);
        step(32'hDEAD_BEEF, 32'h0000_040C, 1, 0, 0, 1, 32'hDEAD_BEEF, 32'h40C, 1, 0);

        // Flush beats stall: bubble, PC+4 held, fetch allowed to advance.
        step(32'h1109_7FFF, 32'h0000_0410, 1, 0, 0, 1, 32'h1109_7FFF, 32'h410, 1, 0);
        step(32'h2222_3333, 32'h0000_0414, 1, 1, 1, 1, 32'h0000_0000, 32'h410, 0, 0);

        // Invalid fetch: NOP enters, PC+4 still follows fetch.
        step(32'hFFFF_FFFF, 32'h0000_0418, 0, 0, 0, 1, 32'h0000_0000, 32'h418, 0, 0);
        // Stalling a bubble does not count.
        step(32'hAAAA_AAAA, 32'h0000_041C, 1, 1, 0, 0, 32'h0000_0000, 32'h418, 0, 0);

        // Flush without stall after a real word.
        step(32'h0C00_0100, 32'h0000_0420, 1, 0, 0, 1, 32'h0C00_0100, 32'h420, 1, 0);
        step(32'h5555_5555, 32'h0000_0424, 1, 0, 1, 1, 32'h0000_0000, 32'h420, 0, 0);

        // Counter saturation over a 300-cycle stall.
        step(32'h1234_5678, 32'h0000_0428, 1, 0, 0, 1, 32'h1234_5678, 32'h428, 1, 0);
        for (int i = 0; i < 300; i++) begin
            step(32'hCAFE_0000 + 32'(i), 32'h0000_042C, 1, 1, 0, 0,
                 32'h1234_5678, 32'h428, 1, (i < 255) ? 8'(i + 1) : 8'd255);
        end

        // Reset mid-stall, between edges: immediate effect.
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("midrst_cnt",   64'(stall_cnt), 64'h0);
        check("midrst_valid", 64'(id_valid),  64'h0);
        check("midrst_instr", 64'(id_instr),  64'h0);
        @(negedge clk);
        #2 reset = 1'b0;
        stall = 1'b0;

        // Pipeline resumes normally after reset.
        step(32'h00A0_0020, 32'h0000_0500, 1, 0, 0, 1, 32'h00A0_0020, 32'h500, 1, 0);

        // Bounded drain of the scoreboard.
        drain = 0;
        while (sb_q.size() > 0 && drain < 5) begin
            @(posedge clk);
            #2;
            drain++;
        end
        check("sb_drained", 64'(sb_q.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
